// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch and data ports; data wins, fetch wins after STARVE_MAX contended losses.
// Latency: grant -> mem_req next cycle -> pulse MEM_LATENCY cycles later; requesters stall by holding req until their pulse.
module unified_mem_arbiter #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_done,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LATENCY);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            own_d_q, own_d_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;

    logic fetch_ok, grant_i, grant_d;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        own_d_d      = own_d_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        flush_pend_d = flush_pend_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        we_d         = we_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        fetch_ok     = if_req && !if_flush;
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_req && fetch_ok) begin
                    if (starve_cnt_q == STARVE_LIM) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d      = 1'b1;
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (fetch_ok) begin
                    grant_i = 1'b1;
                end

                if (grant_i) begin
                    starve_cnt_d = '0;
                    addr_d       = {if_addr[XLEN-1:2], 2'b00};
                    wdata_d      = '0;
                    be_d         = 4'hF;
                    we_d         = 1'b0;
                end else if (grant_d) begin
                    addr_d  = {d_addr[XLEN-1:2], 2'b00};
                    wdata_d = d_wdata;
                    be_d    = d_we ? d_be : 4'hF;
                    we_d    = d_we;
                end

                if (grant_i || grant_d) begin
                    own_d_d   = grant_d;
                    lat_cnt_d = LAT_INIT;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                lat_cnt_d = lat_cnt_q - LW'(1);
                if (!own_d_q && if_flush) begin
                    flush_pend_d = 1'b1;
                end
                // Read data is only guaranteed valid in the last BUSY cycle.
                if (lat_cnt_q == LW'(1)) begin
                    state_d = S_RESP;
                    if (own_d_q && !we_q) begin
                        d_rdata_d = mem_rdata;
                    end else if (!own_d_q) begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                flush_pend_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            own_d_q      <= 1'b0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            flush_pend_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            own_d_q      <= own_d_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            flush_pend_q <= flush_pend_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            we_q         <= we_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    logic busy, resp;
    assign busy = (state_q == S_BUSY);
    assign resp = (state_q == S_RESP);

    // A flush landing in the response cycle itself must still kill the pulse.
    assign if_rvalid = resp && !own_d_q && !flush_pend_q && !if_flush;
    assign d_done    = resp && own_d_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = busy && (lat_cnt_q == LAT_INIT);
    assign mem_we    = busy && we_q;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_be    = busy ? be_q : 4'h0;
endmodule
